// File: rtl/panel_seq.sv
// Control-panel request sequencer: synchronizes and debounces the front-panel keys,
// turns each press into one timed request pulse to P-M and waits for its acknowledge.
module panel_seq #(
  parameter int DEBOUNCE  = 16,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       clm_n,
  input  logic [6:0] key,
  input  logic       run,
  input  logic       p0,
  input  logic       k1,
  input  logic       k2,
  output logic       start__,
  output logic       stop__,
  output logic       cycle,
  output logic       panel_store,
  output logic       panel_fetch,
  output logic       panel_load,
  output logic       panel_bin,
  output logic       busy,
  output logic       err_timeout
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Request codes equal the key bit index, so the priority scan maps directly.
  typedef enum logic [2:0] {
    REQ_STORE = 3'd0,
    REQ_FETCH = 3'd1,
    REQ_LOAD  = 3'd2,
    REQ_BIN   = 3'd3,
    REQ_CYCLE = 3'd4,
    REQ_START = 3'd5,
    REQ_STOP  = 3'd6
  } req_t;

  logic [6:0] sync1_reg;
  logic [6:0] sync2_reg;
  logic [6:0] press;

  always_ff @(posedge clk or negedge clm_n) begin
    if (!clm_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_deb
      logic [DW-1:0] cnt_reg;
      logic          level_reg;
      logic          event_reg;

      always_ff @(posedge clk or negedge clm_n) begin
        if (!clm_n) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          event_reg <= 1'b0;
        end else begin
          event_reg <= 1'b0;
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE - 1)) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg[gi];
            event_reg <= sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = event_reg;
    end
  endgenerate

  state_t        state_reg, state_next;
  req_t          code_reg, code_next;
  logic [PW-1:0] pcnt_reg, pcnt_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          err_reg, err_next;
  logic          seen_k2_reg, seen_k2_next;
  logic          seen_k12_reg, seen_k12_next;
  logic          seen_p0lo_reg, seen_p0lo_next;

  req_t sel_code;
  logic sel_ok;
  logic accept;
  logic ack;

  // Ascending scan: the highest-priority (highest index) pressed key wins.
  always_comb begin
    sel_code = REQ_STORE;
    for (int i = 0; i < 7; i++) begin
      if (press[i]) sel_code = req_t'(i[2:0]);
    end
  end

  always_comb begin
    case (sel_code)
      REQ_STOP:             sel_ok = 1'b1;
      REQ_START, REQ_CYCLE: sel_ok = !run;
      default:              sel_ok = !run && p0;
    endcase
  end

  assign accept = (|press) && sel_ok;

  always_comb begin
    case (code_reg)
      REQ_START: ack = run;
      REQ_STOP:  ack = !run;
      REQ_CYCLE: ack = seen_p0lo_reg && p0;
      REQ_BIN:   ack = seen_k12_reg && p0 && !k1 && !k2;
      default:   ack = seen_k2_reg && p0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    code_next      = code_reg;
    pcnt_next      = pcnt_reg;
    tcnt_next      = tcnt_reg;
    err_next       = err_reg;
    seen_k2_next   = seen_k2_reg;
    seen_k12_next  = seen_k12_reg;
    seen_p0lo_next = seen_p0lo_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next     = PULSE;
          code_next      = sel_code;
          err_next       = 1'b0;
          pcnt_next      = '0;
          seen_k2_next   = 1'b0;
          seen_k12_next  = 1'b0;
          seen_p0lo_next = 1'b0;
        end
      end
      PULSE, WAIT_ACK: begin
        seen_k2_next   = seen_k2_reg || k2;
        seen_k12_next  = seen_k12_reg || k1 || k2;
        seen_p0lo_next = seen_p0lo_reg || !p0;
        // A stop press pre-empts any other outstanding request with no IDLE gap.
        if (press[REQ_STOP] && code_reg != REQ_STOP) begin
          state_next     = PULSE;
          code_next      = REQ_STOP;
          pcnt_next      = '0;
          seen_k2_next   = 1'b0;
          seen_k12_next  = 1'b0;
          seen_p0lo_next = 1'b0;
        end else if (state_reg == PULSE) begin
          if (pcnt_reg == PW'(PULSE_LEN - 1)) begin
            state_next = WAIT_ACK;
            tcnt_next  = '0;
          end else begin
            pcnt_next = pcnt_reg + PW'(1);
          end
        end else begin
          if (ack) begin
            state_next = IDLE;
          end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
            state_next = IDLE;
            err_next   = 1'b1;
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clm_n) begin
    if (!clm_n) begin
      state_reg     <= IDLE;
      code_reg      <= REQ_STORE;
      pcnt_reg      <= '0;
      tcnt_reg      <= '0;
      err_reg       <= 1'b0;
      seen_k2_reg   <= 1'b0;
      seen_k12_reg  <= 1'b0;
      seen_p0lo_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      code_reg      <= code_next;
      pcnt_reg      <= pcnt_next;
      tcnt_reg      <= tcnt_next;
      err_reg       <= err_next;
      seen_k2_reg   <= seen_k2_next;
      seen_k12_reg  <= seen_k12_next;
      seen_p0lo_reg <= seen_p0lo_next;
    end
  end

  logic start_n_reg, stop_n_reg, cycle_reg, store_reg, fetch_reg, load_reg, bin_reg, busy_reg;
  logic pulse_next;

  assign pulse_next = (state_next == PULSE);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge clm_n) begin
    if (!clm_n) begin
      start_n_reg <= 1'b1;
      stop_n_reg  <= 1'b1;
      cycle_reg   <= 1'b0;
      store_reg   <= 1'b0;
      fetch_reg   <= 1'b0;
      load_reg    <= 1'b0;
      bin_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      start_n_reg <= !(pulse_next && code_next == REQ_START);
      stop_n_reg  <= !(pulse_next && code_next == REQ_STOP);
      cycle_reg   <= pulse_next && code_next == REQ_CYCLE;
      store_reg   <= pulse_next && code_next == REQ_STORE;
      fetch_reg   <= pulse_next && code_next == REQ_FETCH;
      load_reg    <= pulse_next && code_next == REQ_LOAD;
      bin_reg     <= pulse_next && code_next == REQ_BIN;
      busy_reg    <= state_next != IDLE;
    end
  end

  assign start__     = start_n_reg;
  assign stop__      = stop_n_reg;
  assign cycle       = cycle_reg;
  assign panel_store = store_reg;
  assign panel_fetch = fetch_reg;
  assign panel_load  = load_reg;
  assign panel_bin   = bin_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_panel_seq.sv
// Bench for panel_seq: a pulse scoreboard plus a small P-M acknowledge model
// driven from per-scenario tasks.
module tb_panel_seq;

  logic       clk;
  logic       clm_n;
  logic [6:0] key;
  logic       run, p0, k1, k2;
  logic       start__, stop__, cycle, panel_store, panel_fetch, panel_load, panel_bin;
  logic       busy, err_timeout;

  panel_seq #(.DEBOUNCE(16), .PULSE_LEN(4), .TIMEOUT(1024)) dut (
    .clk(clk), .clm_n(clm_n), .key(key), .run(run), .p0(p0), .k1(k1), .k2(k2),
    .start__(start__), .stop__(stop__), .cycle(cycle), .panel_store(panel_store),
    .panel_fetch(panel_fetch), .panel_load(panel_load), .panel_bin(panel_bin),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] code;
    int         len;
    int         start;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [6:0] K_STORE = 7'b0000001;
  localparam logic [6:0] K_FETCH = 7'b0000010;
  localparam logic [6:0] K_LOAD  = 7'b0000100;
  localparam logic [6:0] K_BIN   = 7'b0001000;
  localparam logic [6:0] K_CYCLE = 7'b0010000;
  localparam logic [6:0] K_START = 7'b0100000;
  localparam logic [6:0] K_STOP  = 7'b1000000;

  // Pulse monitor: one-hot check every cycle, scoreboard pop at each pulse end.
  logic [6:0] obs, prev_obs = '0;
  int pstart = 0, plen = 0;
  exp_t e;
  always @(negedge clk) begin
    obs = {~stop__, ~start__, cycle, panel_bin, panel_load, panel_fetch, panel_store};
    checks++;
    if ($countones(obs) > 1) begin
      errors++;
      $display("FAIL onehot cyc=%0d outputs=%b required at most one", cyc, obs);
    end
    if (obs != prev_obs) begin
      if (prev_obs != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected code=%b len=%0d start=%0d required none", prev_obs, plen, pstart);
        end else begin
          e = exp_q.pop_front();
          if (prev_obs !== e.code || plen !== e.len || pstart !== e.start) begin
            errors++;
            $display("FAIL pulse code=%b len=%0d start=%0d required code=%b len=%0d start=%0d",
                     prev_obs, plen, pstart, e.code, e.len, e.start);
          end else begin
            $display("pulse code=%b len=%0d start=%0d ok", prev_obs, plen, pstart);
          end
        end
      end
      if (obs != 0) begin
        pstart = cyc;
        plen   = 1;
      end
    end else if (obs != 0) begin
      plen++;
    end
    prev_obs = obs;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic expect_pulse(input logic [6:0] code, input int len, input int start);
    exp_t x;
    x.code  = code;
    x.len   = len;
    x.start = start;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    logic [8:0] v;
    step(2);
    for (int i = 0; i < 6; i++) begin
      key = 7'($urandom);
      @(negedge clk);
      v = {start__, stop__, cycle, panel_store, panel_fetch, panel_load, panel_bin, busy, err_timeout};
      checks++;
      if (v !== 9'b110000000) begin
        errors++;
        $display("FAIL reset_outputs got=%b required=110000000", v);
      end
      step(1);
    end
    key = '0;
    step(2);
    clm_n = 1'b1;
    step(50);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b err=%b required 0 0", busy, err_timeout);
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    key = K_STORE;
    c0 = cyc;
    expect_pulse(K_STORE, 2, c0 + 19);
    step(21);
    clm_n = 1'b0;
    #1;
    checks++;
    if (panel_store !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid store=%b busy=%b required 0 0", panel_store, busy);
    end
    key = '0;
    step(3);
    clm_n = 1'b1;
    step(5);
  endtask

  task automatic test_bounce_store;
    int c0, p;
    for (int i = 0; i < 12; i++) begin
      key = (i % 2 == 0) ? K_STORE : 7'b0;
      step(5);
    end
    key = K_STORE;
    c0 = cyc;
    expect_pulse(K_STORE, 4, c0 + 19);
    step(25);
    key = '0;
    k2 = 1'b1;
    p0 = 1'b0;
    step(10);
    k2 = 1'b0;
    step(2);
    p0 = 1'b1;
    p = cyc;
    wait_neg(p);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL store_ack_hold busy=%b required 1", busy);
    end
    wait_neg(p + 1);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL store_ack_done busy=%b err=%b required 0 0", busy, err_timeout);
    end
    step(25);
  endtask

  task automatic test_reject_priority;
    int c0, p;
    run = 1'b1;
    key = K_FETCH;
    step(25);
    key = '0;
    step(25);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rejected busy=%b required 0", busy);
    end
    run = 1'b0;
    key = K_START | K_LOAD;
    c0 = cyc;
    expect_pulse(K_START, 4, c0 + 19);
    step(25);
    key = '0;
    run = 1'b1;
    p = cyc;
    wait_neg(p);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ack_hold busy=%b required 1", busy);
    end
    wait_neg(p + 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ack_done busy=%b required 0", busy);
    end
    step(25);
    run = 1'b0;
    step(2);
  endtask

  task automatic test_cycle;
    int c0, p;
    key = K_CYCLE;
    c0 = cyc;
    expect_pulse(K_CYCLE, 4, c0 + 19);
    step(25);
    key = '0;
    p0 = 1'b0;
    step(3);
    p0 = 1'b1;
    p = cyc;
    wait_neg(p);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cycle_ack_hold busy=%b required 1", busy);
    end
    wait_neg(p + 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cycle_ack_done busy=%b required 0", busy);
    end
    step(25);
  endtask

  task automatic test_abort;
    int c0, c1, c2, p;
    key = K_BIN;
    c0 = cyc;
    expect_pulse(K_BIN, 4, c0 + 19);
    step(25);
    key = K_STOP;
    c1 = cyc;
    expect_pulse(K_STOP, 4, c1 + 19);
    wait_neg(c1 + 18);
    checks++;
    if (panel_bin !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre bin=%b busy=%b required 0 1", panel_bin, busy);
    end
    wait_neg(c1 + 23);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_ack_hold busy=%b required 1", busy);
    end
    wait_neg(c1 + 24);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_ack_done busy=%b required 0", busy);
    end
    step(1);
    key = '0;
    step(25);
    // Second stop while a stop request is still waiting must be ignored.
    run = 1'b1;
    key = K_STOP;
    c2 = cyc;
    expect_pulse(K_STOP, 4, c2 + 19);
    step(25);
    key = '0;
    step(25);
    key = K_STOP;
    step(25);
    key = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_during_stop busy=%b required 1", busy);
    end
    run = 1'b0;
    p = cyc;
    wait_neg(p + 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop2_ack_done busy=%b required 0", busy);
    end
    step(25);
  endtask

  task automatic test_timeout;
    int c0, c3;
    key = K_LOAD;
    c0 = cyc;
    expect_pulse(K_LOAD, 4, c0 + 19);
    step(25);
    key = '0;
    wait_neg(c0 + 1046);
    checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_last_wait busy=%b err=%b required 1 0", busy, err_timeout);
    end
    wait_neg(c0 + 1047);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag busy=%b err=%b required 0 1", busy, err_timeout);
    end
    step(5);
    key = K_STORE;
    c3 = cyc;
    expect_pulse(K_STORE, 4, c3 + 19);
    wait_neg(c3 + 18);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err=%b required 1", err_timeout);
    end
    wait_neg(c3 + 19);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared err=%b required 0", err_timeout);
    end
    step(6);
    key = '0;
    k2 = 1'b1;
    step(2);
    k2 = 1'b0;
    step(5);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL store_after_timeout busy=%b err=%b required 0 0", busy, err_timeout);
    end
    step(25);
  endtask

  initial begin
    clm_n = 1'b0;
    key   = '0;
    run   = 1'b0;
    p0    = 1'b1;
    k1    = 1'b0;
    k2    = 1'b0;
    test_reset;
    test_reset_mid;
    test_bounce_store;
    test_reject_priority;
    test_cycle;
    test_abort;
    test_timeout;
    step(30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panel_seq.md
Name: panel_seq

Overview:
- Control-panel request sequencer. It is the initiator side of the panel interface that the P-M unit receives.
- Raw front-panel keys pass through a 2-FF synchronizer and a debouncer. Each press becomes exactly one timed request pulse to P-M (START, STOP, CYCLE, STORE, FETCH, LOAD, BIN).
- After the pulse, the block waits for the CPU state acknowledge before it accepts the next key. One request is outstanding at a time; a timeout flags an error.

Parameters:
- DEBOUNCE, 16, cycles a synchronized key level must be stable before it is accepted (≥2).
- PULSE_LEN, 4, cycles each request output is asserted (≥1).
- TIMEOUT, 1024, cycles in WAIT_ACK before abandoning the request (≥2).

Ports:
- clk  in  1  system clock, all flops rise on posedge.
- clm_n  in  1  asynchronous active-low reset.
- key  in  7  raw asynchronous keys, active-high; bit order {stop, start, cycle, bin, load, fetch, store} = [6:0].
- run  in  1  P-M run indicator.
- p0  in  1  P-M P0 state.
- k1  in  1  P-M K1 panel state.
- k2  in  1  P-M K2 panel state.
- start__  out  1  start request, active-low pulse.
- stop__  out  1  stop request, active-low pulse.
- cycle  out  1  cycle request, active-high pulse.
- panel_store  out  1  store request, active-high pulse.
- panel_fetch  out  1  fetch request, active-high pulse.
- panel_load  out  1  load request, active-high pulse.
- panel_bin  out  1  bootstrap request, active-high pulse.
- busy  out  1  high in PULSE and WAIT_ACK.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async, clm_n=0):
  - All synchronizers, debounce counters and debounced levels go to 0; FSM goes to IDLE.
  - Outputs: start__=1, stop__=1, all active-high requests=0, busy=0, err_timeout=0.
  - Reset mid-operation abandons the request and releases pulses immediately. No output glitches to the asserted level.
- Debounce, per key:
  - Counter restarts whenever the synchronized level differs from the debounced level.
  - When it reaches DEBOUNCE-1 with the level unchanged, the debounced level updates on the next edge.
  - A press event is a debounced 0→1 edge, one cycle wide. Releases generate nothing.
  - Press-to-event latency is 2 + DEBOUNCE cycles.
- Acceptance in IDLE:
  - Simultaneous events are resolved by priority stop > start > cycle > bin > load > fetch > store; lower-priority events that cycle are discarded.
  - store/fetch/load/bin are accepted only if run=0 and p0=1. Otherwise they are discarded with no state change.
  - start and cycle are accepted only if run=0. stop is always accepted.
  - An accepted event clears err_timeout and latches the request code.
- States:
  - IDLE: waits for an accepted event, then goes to PULSE on the next edge.
  - PULSE: the selected output is asserted for exactly PULSE_LEN cycles, starting the cycle after the event. The state then goes to WAIT_ACK and the timeout counter is cleared.
  - WAIT_ACK: acknowledge conditions are sampled every cycle, and the state returns to IDLE one cycle after the condition holds. Conditions per request:
    - store/fetch/load: k2 seen high at least once, then p0=1.
    - bin: k1 or k2 seen high, then p0=1 with k1=0 and k2=0.
    - start: run=1.
    - stop: run=0.
    - cycle: p0 seen 0, then p0=1.
  - The "seen" flags are cleared on entry to PULSE.
- Timeout:
  - The counter increments in WAIT_ACK.
  - At TIMEOUT-1 without acknowledge, err_timeout is set and the state returns to IDLE.
  - If acknowledge and timeout coincide, acknowledge wins and err_timeout stays 0.
- Key events while busy:
  - A stop event in PULSE or WAIT_ACK aborts the current request. The current pulse is deasserted the next cycle, and a stop PULSE follows directly with no IDLE gap.
  - A stop during a stop request is ignored.
  - All other events while busy are discarded; nothing is queued.
- Output timing: outputs are registered, and at most one request output is asserted in any cycle.

Test Plan:
- Reset/idle: clm_n=0 with keys toggling → start__=stop__=1, others 0, busy=0; hold 50 cycles after release → no pulse.
- Bounce filter: store key toggled every 5 cycles for 60 cycles, then held high; run=0, p0=1, DEBOUNCE=16 → exactly one panel_store pulse of 4 cycles, starting 19 cycles after the stable hold began.
- Store handshake: after the pulse, model k2=1 for 10 cycles, then p0=1 → busy falls one cycle after p0=1; err_timeout=0.
- Rejection and priority: press fetch with run=1 → no pulse. Press start and load in the same cycle with run=0 → only start__ pulses; busy ends one cycle after the model raises run.
- Abort: during WAIT_ACK of a bin request, press stop → panel_bin already low; stop__ low for 4 cycles; ack when run=0.
- Timeout: load request with k2 never asserted, TIMEOUT=1024 → err_timeout=1 at WAIT_ACK cycle 1024, FSM in IDLE; next accepted key clears the flag.
